// File: rtl/autobaud_ctrl_if.sv
// Handshake/config bundle between autobaud_ctrl and its environment.
// AUTOBAUD_GLITCH_CNT_EN adds the glitch_cnt observation port.
interface autobaud_ctrl_if #(
  parameter int unsigned COUNTER_WIDTH = 24
);
  logic                     start;
  logic                     rx;
  logic                     baud_lock;
  logic                     baud_rst;
  logic [COUNTER_WIDTH-1:0] count_max;
  logic [COUNTER_WIDTH-1:0] sync_min;
  logic [COUNTER_WIDTH-1:0] sync_max;
  logic [COUNTER_WIDTH-1:0] period;
  logic                     busy;
  logic                     done;
  logic                     fail;
`ifdef AUTOBAUD_GLITCH_CNT_EN
  logic [7:0]               glitch_cnt;

  modport master (
    output start, rx, baud_lock,
    input  baud_rst, count_max, sync_min, sync_max, period, busy, done, fail, glitch_cnt
  );
  modport slave (
    input  start, rx, baud_lock,
    output baud_rst, count_max, sync_min, sync_max, period, busy, done, fail, glitch_cnt
  );
`else
  modport master (
    output start, rx, baud_lock,
    input  baud_rst, count_max, sync_min, sync_max, period, busy, done, fail
  );
  modport slave (
    input  start, rx, baud_lock,
    output baud_rst, count_max, sync_min, sync_max, period, busy, done, fail
  );
`endif
endinterface

// File: rtl/autobaud_ctrl.sv
// Auto-baud measurement and sequencing for the baudclock phase-recovery block.
// Optional feature macro: AUTOBAUD_GLITCH_CNT_EN (adds glitch_cnt counter/port).
module autobaud_ctrl #(
  parameter int unsigned COUNTER_WIDTH = 24,
  parameter int unsigned EDGE_COUNT    = 16,
  parameter int unsigned MIN_PERIOD    = 8,
  parameter int unsigned TOL_SHIFT     = 3,
  parameter int unsigned LOCK_WAIT     = 64
) (
  input logic            clk,
  input logic            rst_n,
  autobaud_ctrl_if.slave bus
);

  localparam int unsigned EcW  = (EDGE_COUNT > 2) ? $clog2(EDGE_COUNT) : 1;
  localparam int unsigned BudW = $clog2(LOCK_WAIT + 1);

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;
  localparam cnt_t            CntMax   = '1;
  localparam cnt_t            MinPer   = cnt_t'(MIN_PERIOD);
  localparam logic [EcW-1:0]  EdgeLast = EcW'(EDGE_COUNT - 1);
  localparam logic [BudW-1:0] BudInit  = BudW'(LOCK_WAIT);

  typedef enum logic [2:0] {StIdle, StWaitEdge, StMeasure, StConfig, StRun, StFail} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  cnt_t            cnt_q, cnt_d, min_q, min_d, bp_q, bp_d;
  logic [EcW-1:0]  ecnt_q, ecnt_d;
  logic [BudW-1:0] budget_q, budget_d;
  cnt_t            period_q, period_d, count_max_q, count_max_d;
  cnt_t            sync_min_q, sync_min_d, sync_max_q, sync_max_d;
  logic            baud_rst_q, baud_rst_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d;
`ifdef AUTOBAUD_GLITCH_CNT_EN
  logic [7:0]      glitch_q, glitch_d;
`endif

  logic           edge_det;
  logic [EcW-1:0] ecnt_inc;

  always_comb begin
    edge_det = sync2_q ^ prev_q;
    ecnt_inc = ecnt_q + EcW'(1);

    state_d     = state_q;
    sync1_d     = bus.rx;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    cnt_d       = (cnt_q == CntMax) ? cnt_q : cnt_q + cnt_t'(1);
    min_d       = min_q;
    bp_d        = bp_q;
    ecnt_d      = ecnt_q;
    budget_d    = budget_q;
    period_d    = period_q;
    count_max_d = count_max_q;
    sync_min_d  = sync_min_q;
    sync_max_d  = sync_max_q;
    done_d      = done_q;
`ifdef AUTOBAUD_GLITCH_CNT_EN
    glitch_d    = glitch_q;
`endif

    // The counter reloads with 1 on an edge: the edge cycle itself is part of the interval.
    unique case (state_q)
      StIdle: ;
      StWaitEdge: begin
        if (edge_det) begin
          state_d = StMeasure;
          cnt_d   = cnt_t'(1);
          min_d   = CntMax;
          ecnt_d  = '0;
        end
      end
      StMeasure: begin
        if (edge_det) begin
          if (cnt_q < MinPer) begin
`ifdef AUTOBAUD_GLITCH_CNT_EN
            if (glitch_q != 8'hff) glitch_d = glitch_q + 8'd1;
`endif
          end else begin
            cnt_d  = cnt_t'(1);
            ecnt_d = ecnt_inc;
            if (cnt_q < min_q) min_d = cnt_q;
            if (ecnt_inc == EdgeLast) state_d = StConfig;
          end
        end else if (cnt_q == CntMax) begin
          state_d = StFail;
        end
      end
      StConfig: begin
        period_d    = min_q;
        count_max_d = min_q - cnt_t'(1);
        sync_max_d  = min_q >> TOL_SHIFT;
        sync_min_d  = count_max_d - sync_max_d;
        bp_d        = '0;
        budget_d    = BudInit;
        state_d     = StRun;
      end
      StRun: begin
        if (!done_q) begin
          if (bus.baud_lock && budget_q != '0) begin
            done_d = 1'b1;
          end else if (budget_q == '0) begin
            state_d = StFail;
          end else if (bp_q == count_max_q) begin
            bp_d     = '0;
            budget_d = budget_q - BudW'(1);
          end else begin
            bp_d = bp_q + cnt_t'(1);
          end
        end
      end
      StFail: ;
      default: state_d = StIdle;
    endcase

    if (bus.start) begin
      state_d = StWaitEdge;
`ifdef AUTOBAUD_GLITCH_CNT_EN
      glitch_d = '0;
`endif
    end

    busy_d     = state_d inside {StWaitEdge, StMeasure, StConfig};
    fail_d     = (state_d == StFail);
    baud_rst_d = (state_d != StRun);
    done_d     = done_d && (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      min_q       <= '1;
      bp_q        <= '0;
      ecnt_q      <= '0;
      budget_q    <= '0;
      period_q    <= '0;
      count_max_q <= '0;
      sync_min_q  <= '0;
      sync_max_q  <= '0;
      baud_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
`ifdef AUTOBAUD_GLITCH_CNT_EN
      glitch_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      min_q       <= min_d;
      bp_q        <= bp_d;
      ecnt_q      <= ecnt_d;
      budget_q    <= budget_d;
      period_q    <= period_d;
      count_max_q <= count_max_d;
      sync_min_q  <= sync_min_d;
      sync_max_q  <= sync_max_d;
      baud_rst_q  <= baud_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
`ifdef AUTOBAUD_GLITCH_CNT_EN
      glitch_q    <= glitch_d;
`endif
    end
  end

  assign bus.baud_rst  = baud_rst_q;
  assign bus.count_max = count_max_q;
  assign bus.sync_min  = sync_min_q;
  assign bus.sync_max  = sync_max_q;
  assign bus.period    = period_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
`ifdef AUTOBAUD_GLITCH_CNT_EN
  assign bus.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_autobaud_ctrl.sv
// Scoreboard bench for autobaud_ctrl: stimulus pushes expected events, a negedge monitor
// pops and compares them when busy falls, done rises or fail rises.
module tb_autobaud_ctrl;
  localparam int unsigned CW = 12;
  localparam int unsigned EC = 16;
  localparam int unsigned MP = 8;
  localparam int unsigned TS = 3;
  localparam int unsigned LW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  autobaud_ctrl_if #(.COUNTER_WIDTH(CW)) bus ();

  autobaud_ctrl #(
    .COUNTER_WIDTH(CW), .EDGE_COUNT(EC), .MIN_PERIOD(MP), .TOL_SHIFT(TS), .LOCK_WAIT(LW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef enum int {EvConfig = 0, EvDone = 1, EvFail = 2} ev_e;
  typedef struct {
    ev_e         kind;
    int unsigned period;
    int unsigned glitches;
    int unsigned fail_after;  // 0: timing not checked
  } exp_t;

  exp_t        sb_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  longint unsigned cyc = 0;
  longint unsigned run_cyc = 0;
  int unsigned last_period = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: walk the rx toggle gaps, accumulate time since the last accepted edge.
  task automatic model(input int unsigned gaps[$], output int unsigned per,
                       output int unsigned glitches);
    int unsigned acc = 0;
    int unsigned n = 0;
    per = (1 << CW) - 1;
    glitches = 0;
    for (int i = 0; i < gaps.size(); i++) begin
      if (n == EC - 1) break;
      acc += gaps[i];
      if (acc < MP) glitches++;
      else begin
        if (acc < per) per = acc;
        acc = 0;
        n++;
      end
    end
  endtask

  task automatic handle_event(input ev_e kind);
    exp_t e;
    int unsigned p;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
      return;
    end
    e = sb_q.pop_front();
    check("event_kind", kind, e.kind);
    p = e.period;
    case (e.kind)
      EvConfig: begin
        check("period", bus.period, p);
        check("count_max", bus.count_max, p - 1);
        check("sync_max", bus.sync_max, p / (1 << TS));
        check("sync_min", bus.sync_min, (p - 1) - p / (1 << TS));
        check("cfg_baud_rst", bus.baud_rst, 0);
`ifdef AUTOBAUD_GLITCH_CNT_EN
        check("glitch_cnt", bus.glitch_cnt, e.glitches);
`endif
      end
      EvDone: begin
        check("done_baud_rst", bus.baud_rst, 0);
        check("done_fail", bus.fail, 0);
        check("done_period_stable", bus.period, p);
      end
      default: begin
        check("fail_baud_rst", bus.baud_rst, 1);
        check("fail_busy", bus.busy, 0);
        check("fail_done", bus.done, 0);
        if (e.fail_after != 0) begin
          checks++;
          if (cyc - run_cyc + 1 < e.fail_after || cyc - run_cyc > e.fail_after + 3) begin
            errors++;
            $display("FAIL lock_timeout_time: got %0d cycles, expected about %0d",
                     cyc - run_cyc, e.fail_after);
          end
        end
      end
    endcase
  endtask

  logic prev_busy = 1'b0, prev_done = 1'b0, prev_fail = 1'b0, prev_brst = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (prev_brst && !bus.baud_rst) run_cyc = cyc;
      if (!prev_fail && bus.fail) handle_event(EvFail);
      else if (prev_busy && !bus.busy) handle_event(EvConfig);
      if (!prev_done && bus.done) handle_event(EvDone);
    end
    prev_busy = bus.busy;
    prev_done = bus.done;
    prev_fail = bus.fail;
    prev_brst = bus.baud_rst;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic send_stream(input int unsigned gaps[$]);
    bus.rx = ~bus.rx;
    for (int i = 0; i < gaps.size(); i++) begin
      tick(gaps[i]);
      bus.rx = ~bus.rx;
    end
  endtask

  task automatic wait_drain(input int unsigned budget, input string name);
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending events, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_baud_rst"}, bus.baud_rst, 1);
    check({tag, "_period"}, bus.period, 0);
    check({tag, "_count_max"}, bus.count_max, 0);
    check({tag, "_sync_min"}, bus.sync_min, 0);
    check({tag, "_sync_max"}, bus.sync_max, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_fail"}, bus.fail, 0);
    tick(0);
  endtask

  // Push a Config expectation for the stream, then run a full measurement with it.
  task automatic run_measure(input int unsigned gaps[$], input string name);
    exp_t e;
    int unsigned per, gl;
    model(gaps, per, gl);
    e = '{kind: EvConfig, period: per, glitches: gl, fail_after: 0};
    sb_q.push_back(e);
    pulse_start();
    tick(3);
    send_stream(gaps);
    wait_drain(50, name);
    last_period = per;
  endtask

  task automatic expect_lock(input int unsigned delay);
    exp_t e;
    e = '{kind: EvDone, period: last_period, glitches: 0, fail_after: 0};
    tick(delay);
    sb_q.push_back(e);
    bus.baud_lock = 1'b1;
    wait_drain(10, "lock");
    bus.baud_lock = 1'b0;
  endtask

  initial begin
    int unsigned gaps[$];
    exp_t e;
    bus.start = 1'b0;
    bus.rx = 1'b1;
    bus.baud_lock = 1'b0;

    tick(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick(2);

    // Uniform 100-cycle intervals, then lock after ~500 cycles.
    gaps.delete();
    for (int i = 0; i < EC - 1; i++) gaps.push_back(100);
    run_measure(gaps, "uniform100");
    expect_lock(490);
    tick(200);
    @(negedge clk);
    check("done_held", bus.done, 1);
    check("done_no_fail", bus.fail, 0);
    tick(0);

    // 300/100/200 pattern with a short double-edge glitch; no lock -> timeout.
    gaps.delete();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        gaps.push_back(2);
        gaps.push_back(1);
        gaps.push_back(297);
      end else gaps.push_back(300);
      gaps.push_back(100);
      gaps.push_back(200);
    end
    run_measure(gaps, "alt_glitch");
    e = '{kind: EvFail, period: last_period, glitches: 0, fail_after: LW * last_period};
    sb_q.push_back(e);
    wait_drain(LW * last_period + 200, "lock_timeout");

    // Randomized streams with random glitches, each followed by a lock.
    for (int r = 0; r < 3; r++) begin
      int unsigned base;
      base = $urandom_range(20, 150);
      gaps.delete();
      for (int i = 0; i < EC - 1; i++) begin
        int unsigned g;
        g = $urandom_range(base, 2 * base);
        if ($urandom_range(0, 3) == 0) begin
          gaps.push_back($urandom_range(1, 3));
          gaps.push_back($urandom_range(1, 3));
        end
        gaps.push_back(g);
      end
      run_measure(gaps, "random");
      expect_lock($urandom_range(20, 16 * base));
    end

    // Restart mid-measurement: old config must survive, edge count and minimum must restart.
    pulse_start();
    tick(3);
    gaps.delete();
    for (int i = 0; i < 6; i++) gaps.push_back(60);
    send_stream(gaps);
    tick(30);
    pulse_start();
    @(negedge clk);
    check("restart_busy", bus.busy, 1);
    check("restart_baud_rst", bus.baud_rst, 1);
    check("restart_done", bus.done, 0);
    check("restart_period_kept", bus.period, last_period);
    check("restart_count_max_kept", bus.count_max, last_period - 1);
    tick(10);
    gaps.delete();
    for (int i = 0; i < EC - 2; i++) gaps.push_back(150);
    gaps.push_back(130);
    run_measure(gaps, "restart");

    // Static rx after the first edge: the interval counter saturates.
    pulse_start();
    tick(3);
    bus.rx = ~bus.rx;
    e = '{kind: EvFail, period: 0, glitches: 0, fail_after: 0};
    sb_q.push_back(e);
    wait_drain((1 << CW) + 50, "saturate");
    tick(20);
    @(negedge clk);
    check("fail_sticky", bus.fail, 1);
    check("fail_sticky_baud_rst", bus.baud_rst, 1);
    tick(0);
    pulse_start();
    @(negedge clk);
    check("fail_cleared_by_start", bus.fail, 0);
    check("start_busy", bus.busy, 1);
    tick(0);

    // Reset while running.
    gaps.delete();
    for (int i = 0; i < EC - 1; i++) gaps.push_back(100);
    run_measure(gaps, "pre_reset");
    tick(20);
    rst_n = 1'b0;
    tick(1);
    check_reset_vals("run_reset");
    rst_n = 1'b1;
    tick(5);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
